// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator between the pipeline and a word-addressed
// data memory. Byte addresses become word addresses. Sub-word stores run as
// read-modify-write sequences, because the memory only writes whole words.
// Handshake rule for both request and response channels: a transfer happens on
// the rising edge where valid and ready are both high. The producer keeps valid
// and its payload stable until that edge.
module mem_access_unit #(
    parameter int P_MEM_WORDS = 4096
) (
    input  logic        iClk,
    input  logic        nRst,
    input  logic        iReqValid,
    output logic        oReqReady,
    input  logic        iReqWrite,
    input  logic [2:0]  iReqFunct3,
    input  logic [31:0] iReqAddr,
    input  logic [31:0] iReqWData,
    output logic        oRspValid,
    input  logic        iRspReady,
    output logic [31:0] oRspData,
    output logic        oRspErr,
    output logic        oMemEn,
    output logic        oMemReadnWrite,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemWData,
    input  logic [31:0] iMemRData,
    output logic [1:0]  oDbgState
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [2:0]  F3_B  = 3'd0;
    localparam logic [2:0]  F3_H  = 3'd1;
    localparam logic [2:0]  F3_W  = 3'd2;
    localparam logic [2:0]  F3_BU = 3'd4;
    localparam logic [2:0]  F3_HU = 3'd5;
    localparam logic [31:0] MEM_WORDS = 32'(P_MEM_WORDS);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;      // captured read word, merged for sub-word stores
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        err_q, err_d;

    logic        req_err;
    logic [31:0] word_addr;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merged;
    logic        req_ready;

    assign word_addr = {2'b00, addr_q[31:2]};

    // Classify an incoming request: illegal funct3, misalignment or out-of-range word.
    always_comb begin
        req_err = 1'b0;
        if (iReqWrite) begin
            if (!(iReqFunct3 == F3_B || iReqFunct3 == F3_H || iReqFunct3 == F3_W)) req_err = 1'b1;
        end else begin
            if (!(iReqFunct3 == F3_B || iReqFunct3 == F3_H || iReqFunct3 == F3_W ||
                  iReqFunct3 == F3_BU || iReqFunct3 == F3_HU)) req_err = 1'b1;
        end
        if ((iReqFunct3 == F3_H || iReqFunct3 == F3_HU) && iReqAddr[0]) req_err = 1'b1;
        if (iReqFunct3 == F3_W && iReqAddr[1:0] != 2'b00) req_err = 1'b1;
        if ({2'b00, iReqAddr[31:2]} >= MEM_WORDS) req_err = 1'b1;
    end

    // Extract and extend the addressed byte/half of the read word for loads.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_sel = iMemRData[7:0];
            2'd1:    byte_sel = iMemRData[15:8];
            2'd2:    byte_sel = iMemRData[23:16];
            default: byte_sel = iMemRData[31:24];
        endcase
        half_sel = addr_q[1] ? iMemRData[31:16] : iMemRData[15:0];
        case (funct3_q)
            F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_val = {24'h0, byte_sel};
            F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_val = {16'h0, half_sel};
            F3_W:    load_val = iMemRData;
            default: load_val = 32'h0;
        endcase
    end

    // Merge store data into the read word for SB/SH; other bits keep the read value.
    always_comb begin
        merged = iMemRData;
        if (funct3_q == F3_B) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (funct3_q == F3_H) begin
            if (addr_q[1]) merged[31:16] = wdata_q[15:0];
            else           merged[15:0]  = wdata_q[15:0];
        end
    end

    // Next-state and output decode; memory is only driven in RD and WR.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        funct3_d   = funct3_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rsp_data_d = rsp_data_q;
        err_d      = err_q;
        req_ready      = 1'b0;
        oRspValid      = 1'b0;
        oMemEn         = 1'b0;
        oMemReadnWrite = 1'b1;
        oMemAddr       = 32'h0;
        oMemWData      = 32'h0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (iReqValid) begin
                    addr_d     = iReqAddr;
                    funct3_d   = iReqFunct3;
                    write_d    = iReqWrite;
                    wdata_d    = iReqWData;
                    rsp_data_d = 32'h0;
                    err_d      = req_err;
                    if (req_err)                                state_d = S_RESP;
                    else if (iReqWrite && iReqFunct3 == F3_W)   state_d = S_WR;
                    else                                        state_d = S_RD;
                end
            end
            S_RD: begin
                oMemEn   = 1'b1;
                oMemAddr = word_addr;
                if (!write_q) begin
                    rdata_d    = iMemRData;
                    rsp_data_d = load_val;
                    state_d    = S_RESP;
                end else begin
                    rdata_d = merged;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                oMemEn         = 1'b1;
                oMemReadnWrite = 1'b0;
                oMemAddr       = word_addr;
                oMemWData      = (funct3_q == F3_W) ? wdata_q : rdata_q;
                state_d        = S_RESP;
            end
            S_RESP: begin
                oRspValid = 1'b1;
                if (iRspReady) begin
                    state_d    = S_IDLE;
                    rsp_data_d = 32'h0;
                    err_d      = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge iClk) begin
        if (!nRst) begin
            state_q    <= S_IDLE;
            addr_q     <= 32'h0;
            funct3_q   <= 3'h0;
            write_q    <= 1'b0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            rsp_data_q <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            funct3_q   <= funct3_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rsp_data_q <= rsp_data_d;
            err_q      <= err_d;
        end
    end

    assign oReqReady = req_ready & nRst;
    assign oRspData  = rsp_data_q;
    assign oRspErr   = err_q;
    assign oDbgState = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory.
module tb_mem_access_unit;

    logic        iClk = 1'b0;
    logic        nRst;
    logic        iReqValid;
    logic        oReqReady;
    logic        iReqWrite;
    logic [2:0]  iReqFunct3;
    logic [31:0] iReqAddr;
    logic [31:0] iReqWData;
    logic        oRspValid;
    logic        iRspReady;
    logic [31:0] oRspData;
    logic        oRspErr;
    logic        oMemEn;
    logic        oMemReadnWrite;
    logic [31:0] oMemAddr;
    logic [31:0] oMemWData;
    logic [31:0] iMemRData;
    logic [1:0]  oDbgState;

    int n_vec = 0;
    int n_err = 0;

    // clock / reset block
    always #5 iClk = ~iClk;

    mem_access_unit #(.P_MEM_WORDS(4096)) dut (
        .iClk(iClk), .nRst(nRst),
        .iReqValid(iReqValid), .oReqReady(oReqReady), .iReqWrite(iReqWrite),
        .iReqFunct3(iReqFunct3), .iReqAddr(iReqAddr), .iReqWData(iReqWData),
        .oRspValid(oRspValid), .iRspReady(iRspReady), .oRspData(oRspData), .oRspErr(oRspErr),
        .oMemEn(oMemEn), .oMemReadnWrite(oMemReadnWrite), .oMemAddr(oMemAddr),
        .oMemWData(oMemWData), .iMemRData(iMemRData), .oDbgState(oDbgState)
    );

    // memory model: combinational read, write on the edge, plus a preload port
    logic [31:0] mem [0:4095];
    int          wr_count = 0;
    logic        pre_en = 1'b0;
    logic [11:0] pre_addr = 12'h0;
    logic [31:0] pre_data = 32'h0;

    always_comb iMemRData = (oMemAddr < 32'd4096) ? mem[oMemAddr[11:0]] : 32'h0;

    always @(posedge iClk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (oMemEn && !oMemReadnWrite) begin
            wr_count <= wr_count + 1;
            if (oMemAddr < 32'd4096) mem[oMemAddr[11:0]] <= oMemWData;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // scoreboard check
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(negedge iClk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge iClk);
        #1 pre_en = 1'b0;
    endtask

    // transaction results
    int          r_lat, r_rd_at, r_wr_at;
    logic [31:0] r_wr_addr, r_data;
    logic        r_err;

    // driver: one request, observe memory activity, take response immediately
    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
        int guard;
        @(negedge iClk);
        iReqValid = 1'b1; iReqWrite = wr; iReqFunct3 = f3; iReqAddr = addr; iReqWData = wd;
        guard = 0;
        while (!oReqReady && guard < 20) begin
            @(negedge iClk);
            guard++;
        end
        check("accept_ready", {31'h0, oReqReady}, 32'h1);
        @(posedge iClk);
        r_lat = 0; r_rd_at = 0; r_wr_at = 0; r_wr_addr = 32'h0;
        do begin
            @(negedge iClk);
            iReqValid = 1'b0;
            r_lat++;
            if (oMemEn) begin
                if (oMemReadnWrite) r_rd_at = r_lat;
                else begin
                    r_wr_at = r_lat;
                    r_wr_addr = oMemAddr;
                end
            end
        end while (!oRspValid && r_lat < 8);
        r_data = oRspData;
        r_err  = oRspErr;
        iRspReady = 1'b1;
        @(posedge iClk);
        #1 iRspReady = 1'b0;
        check("rsp_drop", {31'h0, oRspValid}, 32'h0);
        check("ready_back", {31'h0, oReqReady}, 32'h1);
    endtask

    task automatic check_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] exp);
        do_req(1'b0, f3, addr, 32'h0);
        check(tag, r_data, exp);
        check({tag, "_lat"}, r_lat, 2);
        check({tag, "_rd"}, r_rd_at, 1);
        check({tag, "_err"}, {31'h0, r_err}, 32'h0);
    endtask

    task automatic check_error(input string tag, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr);
        int wc;
        wc = wr_count;
        do_req(wr, f3, addr, 32'h1234_5678);
        check({tag, "_err"}, {31'h0, r_err}, 32'h1);
        check({tag, "_data"}, r_data, 32'h0);
        check({tag, "_lat"}, r_lat, 1);
        check({tag, "_mem_en"}, r_rd_at + r_wr_at, 0);
        check({tag, "_wr_cnt"}, wr_count, wc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, {31'h0, oRspValid}, 32'h0);
        check({tag, "_rsp_data"}, oRspData, 32'h0);
        check({tag, "_rsp_err"}, {31'h0, oRspErr}, 32'h0);
        check({tag, "_mem_en"}, {31'h0, oMemEn}, 32'h0);
        check({tag, "_mem_rnw"}, {31'h0, oMemReadnWrite}, 32'h1);
        check({tag, "_mem_addr"}, oMemAddr, 32'h0);
        check({tag, "_mem_wdata"}, oMemWData, 32'h0);
    endtask

    initial begin
        int wc;
        nRst = 1'b0; iReqValid = 1'b0; iReqWrite = 1'b0; iReqFunct3 = 3'h0;
        iReqAddr = 32'h0; iReqWData = 32'h0; iRspReady = 1'b0;

        // reset state
        preload(12'd3, 32'h80FF_7F01);
        repeat (2) @(negedge iClk);
        check("rst_ready_low", {31'h0, oReqReady}, 32'h0);
        check_reset_outputs("rst");
        nRst = 1'b1;
        @(negedge iClk);
        check("rst_ready_high", {31'h0, oReqReady}, 32'h1);

        // load extension
        check_load("lb_0c",  3'd0, 32'h0C, 32'h0000_0001);
        check_load("lb_0d",  3'd0, 32'h0D, 32'h0000_007F);
        check_load("lb_0e",  3'd0, 32'h0E, 32'hFFFF_FFFF);
        check_load("lbu_0f", 3'd4, 32'h0F, 32'h0000_0080);
        check_load("lh_0e",  3'd1, 32'h0E, 32'hFFFF_80FF);
        check_load("lhu_0c", 3'd5, 32'h0C, 32'h0000_7F01);
        check_load("lw_0c",  3'd2, 32'h0C, 32'h80FF_7F01);

        // sub-word stores
        preload(12'd3, 32'h1122_3344);
        do_req(1'b1, 3'd0, 32'h0D, 32'h0000_00AA);
        check("sb_rd_cycle", r_rd_at, 1);
        check("sb_wr_cycle", r_wr_at, 2);
        check("sb_wr_addr", r_wr_addr, 32'd3);
        check("sb_lat", r_lat, 3);
        check("sb_rsp", r_data, 32'h0);
        check("sb_err", {31'h0, r_err}, 32'h0);
        check("sb_mem", mem[3], 32'h1122_AA44);
        do_req(1'b1, 3'd1, 32'h0E, 32'h0000_BEEF);
        check("sh_lat", r_lat, 3);
        check("sh_mem", mem[3], 32'hBEEF_AA44);
        check_load("lw_after_sh", 3'd2, 32'h0C, 32'hBEEF_AA44);

        // full-word store
        do_req(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
        check("sw_no_rd", r_rd_at, 0);
        check("sw_wr_cycle", r_wr_at, 1);
        check("sw_wr_addr", r_wr_addr, 32'd4);
        check("sw_lat", r_lat, 2);
        check_load("lw_after_sw", 3'd2, 32'h10, 32'hDEAD_BEEF);

        // errors
        check_error("lw_mis", 1'b0, 3'd2, 32'h02);
        check_error("lh_mis", 1'b0, 3'd1, 32'h01);
        check_error("ld_f3_3", 1'b0, 3'd3, 32'h00);
        check_error("sw_oob", 1'b1, 3'd2, 32'd16384);
        check_error("sbu_f3_4", 1'b1, 3'd4, 32'h00);

        // backpressure with a held follow-up request
        @(negedge iClk);
        iReqValid = 1'b1; iReqWrite = 1'b0; iReqFunct3 = 3'd2; iReqAddr = 32'h10;
        @(posedge iClk);
        @(negedge iClk);
        iReqFunct3 = 3'd4; iReqAddr = 32'h0F;           // LBU held from here on
        check("bp_rd_ready", {31'h0, oReqReady}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge iClk);
            check("bp_valid", {31'h0, oRspValid}, 32'h1);
            check("bp_data", oRspData, 32'hDEAD_BEEF);
            check("bp_ready", {31'h0, oReqReady}, 32'h0);
        end
        iRspReady = 1'b1;
        @(posedge iClk);
        #1 iRspReady = 1'b0;
        check("bp_after_valid", {31'h0, oRspValid}, 32'h0);
        check("bp_after_ready", {31'h0, oReqReady}, 32'h1);
        @(posedge iClk);
        @(negedge iClk);
        iReqValid = 1'b0;
        check("bp_next_rd_en", {31'h0, oMemEn}, 32'h1);
        check("bp_next_rd_addr", oMemAddr, 32'd3);
        @(negedge iClk);
        check("bp_next_valid", {31'h0, oRspValid}, 32'h1);
        check("bp_next_data", oRspData, 32'h0000_00BE);
        iRspReady = 1'b1;
        @(posedge iClk);
        #1 iRspReady = 1'b0;

        // reset in the RD cycle of an SB
        preload(12'd5, 32'hCAFE_F00D);
        wc = wr_count;
        @(negedge iClk);
        iReqValid = 1'b1; iReqWrite = 1'b1; iReqFunct3 = 3'd0; iReqAddr = 32'h15; iReqWData = 32'h11;
        @(posedge iClk);
        @(negedge iClk);
        iReqValid = 1'b0;
        check("rst_sb_in_rd", {31'h0, oMemEn & oMemReadnWrite}, 32'h1);
        nRst = 1'b0;
        @(posedge iClk);
        #1;
        check("rst_sb_ready_low", {31'h0, oReqReady}, 32'h0);
        check_reset_outputs("rst_sb");
        @(negedge iClk);
        nRst = 1'b1;
        repeat (2) @(negedge iClk);
        check("rst_sb_ready", {31'h0, oReqReady}, 32'h1);
        check("rst_sb_no_write", wr_count, wc);
        check("rst_sb_mem", mem[5], 32'hCAFE_F00D);
        check_reset_outputs("rst_sb_idle");

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
